// File: rtl/plru_tracker_pkg.sv
// plru_pkg: shared geometry, FSM state type and tree-update function for plru_tracker.
package plru_pkg;
  localparam int NUM_WAYS = 8;
  localparam int NUM_SETS = 8;
  localparam int WAY_W = $clog2(NUM_WAYS);
  localparam int SET_W = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1;
  localparam int TREE_W = NUM_WAYS - 1;
  typedef enum logic [1:0] {IDLE, WALK, DONE} state_e;
  // Bits are heap-ordered: node n lives at h[n], h[0] is a spare slot.
  function automatic logic [TREE_W-1:0] plru_update(input logic [TREE_W-1:0] bits, input logic [WAY_W-1:0] way);
    logic [NUM_WAYS-1:0] h;
    logic [WAY_W-1:0] a;
    logic [WAY_W-1:0] w;
    h = {bits, 1'b0};
    a = WAY_W'(1);
    w = way;
    for (int l = 0; l < WAY_W; l++) begin
      h[a] = ~w[WAY_W-1];
      a = (a << 1) | WAY_W'(w[WAY_W-1]);
      w = w << 1;
    end
    return h[NUM_WAYS-1:1];
  endfunction
endpackage

// File: rtl/plru_tracker_if.sv
// plru_tracker_if: touch and victim-query signals between cache controller and plru_tracker.
interface plru_tracker_if;
  import plru_pkg::*;
  logic touch;
  logic [SET_W-1:0] touch_set;
  logic [WAY_W-1:0] touch_way;
  logic query_req;
  logic [SET_W-1:0] query_set;
  logic busy;
  logic victim_valid;
  logic [WAY_W-1:0] victim_way;
  modport master (output touch, touch_set, touch_way, query_req, query_set, input busy, victim_valid, victim_way);
  modport slave (input touch, touch_set, touch_way, query_req, query_set, output busy, victim_valid, victim_way);
endinterface

// File: rtl/plru_touch_update.sv
// plru_touch_update: combinational tree-bit update pointing every path node away from way_i.
module plru_touch_update
  import plru_pkg::*;
(
  input  logic [TREE_W-1:0] bits_i,
  input  logic [WAY_W-1:0]  way_i,
  output logic [TREE_W-1:0] bits_o
);
  assign bits_o = plru_update(bits_i, way_i);
endmodule

// File: rtl/plru_tracker.sv
// plru_tracker: per-set tree pseudo-LRU state and multi-cycle victim walk.
// Optional PLRU_AUTO_TOUCH_EN makes each returned victim MRU in its set.
module plru_tracker
  import plru_pkg::*;
(
  input logic clk,
  input logic rst_n,
  plru_tracker_if.slave bus
);
  state_e state_q, state_d;
  logic [TREE_W-1:0] tree_q [NUM_SETS];
  logic [TREE_W-1:0] snap_q, snap_d, touch_bits;
  logic [WAY_W-1:0] node_q, node_d, victim_q, victim_d;
  logic [NUM_WAYS-1:0] heap;
  logic [WAY_W:0] step;
  logic accept;
  assign heap = {snap_q, 1'b0};
  assign step = {node_q, heap[node_q]};
  assign accept = bus.query_req && state_q != WALK;
  assign bus.busy = state_q == WALK;
  assign bus.victim_valid = state_q == DONE;
  assign bus.victim_way = victim_q;
  plru_touch_update u_touch (.bits_i(tree_q[bus.touch_set]), .way_i(bus.touch_way), .bits_o(touch_bits));
  always_comb begin
    state_d = accept ? WALK : IDLE;
    snap_d = accept ? tree_q[bus.query_set] : snap_q;
    node_d = accept ? WAY_W'(1) : node_q;
    victim_d = victim_q;
    if (state_q == WALK) begin
      node_d = step[WAY_W-1:0];
      state_d = step[WAY_W] ? DONE : WALK;
      victim_d = step[WAY_W] ? step[WAY_W-1:0] : victim_q;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      snap_q <= '0;
      node_q <= '0;
      victim_q <= '0;
    end else begin
      state_q <= state_d;
      snap_q <= snap_d;
      node_q <= node_d;
      victim_q <= victim_d;
    end
  end
`ifdef PLRU_AUTO_TOUCH_EN
  logic [SET_W-1:0] set_q;
  logic [TREE_W-1:0] auto_bits;
  logic auto_en;
  // An external touch to the same set wins over the implicit victim touch.
  assign auto_en = state_q == DONE && !(bus.touch && bus.touch_set == set_q);
  plru_touch_update u_auto (.bits_i(tree_q[set_q]), .way_i(victim_q), .bits_o(auto_bits));
  always_ff @(posedge clk) set_q <= !rst_n ? '0 : accept ? bus.query_set : set_q;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SETS; i++) tree_q[i] <= '0;
    end else begin
      if (bus.touch) tree_q[bus.touch_set] <= touch_bits;
`ifdef PLRU_AUTO_TOUCH_EN
      if (auto_en) tree_q[set_q] <= auto_bits;
`endif
    end
  end
endmodule

// File: tb/tb_plru_tracker.sv
// tb_plru_tracker: randomized and directed checks of plru_tracker against a node-array PLRU model.
module tb_plru_tracker;
  import plru_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  int tm [NUM_SETS][NUM_WAYS];
  plru_tracker_if bus ();
  plru_tracker dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int s = 0; s < NUM_SETS; s++)
      for (int n = 0; n < NUM_WAYS; n++) tm[s][n] = 0;
  endtask

  task automatic model_touch(input int s, input int w);
    int leaf;
    leaf = NUM_WAYS + w;
    for (int d = 0; d < WAY_W; d++)
      tm[s][leaf >> (WAY_W - d)] = ((leaf >> (WAY_W - d - 1)) & 1) != 0 ? 0 : 1;
  endtask

  function automatic int model_victim(input int s);
    int n;
    n = 1;
    while (n < NUM_WAYS) n = 2 * n + tm[s][n];
    return n - NUM_WAYS;
  endfunction

  task automatic do_touch(input int s, input int w);
    bus.touch = 1'b1;
    bus.touch_set = SET_W'(s);
    bus.touch_way = WAY_W'(w);
    tick();
    bus.touch = 1'b0;
    model_touch(s, w);
  endtask

  // mode: 0 none, 1 touch at acceptance edge, 2 touch one edge later, 3 touch during the strobe
  task automatic do_query(input int s, input int mode, input int ts, input int tw, output int got);
    int exp, lat;
    exp = model_victim(s);
    bus.query_req = 1'b1;
    bus.query_set = SET_W'(s);
    bus.touch = mode == 1;
    bus.touch_set = SET_W'(ts);
    bus.touch_way = WAY_W'(tw);
    tick();
    bus.query_req = 1'b0;
    bus.touch = mode == 2;
    if (mode == 1 || mode == 2) model_touch(ts, tw);
    lat = 0;
    while (bus.victim_valid !== 1'b1 && lat < 10) begin
      vectors++;
      if (bus.busy !== 1'b1) begin
        miscompares++;
        $display("FAIL busy_walk set=%0d got=%b want=1", s, bus.busy);
      end
      tick();
      bus.touch = 1'b0;
      lat++;
    end
    vectors++;
    if (lat !== WAY_W) begin
      miscompares++;
      $display("FAIL latency set=%0d got=%0d want=%0d", s, lat, WAY_W);
    end
    vectors++;
    if (bus.victim_way !== WAY_W'(exp)) begin
      miscompares++;
      $display("FAIL victim set=%0d got=%0d want=%0d", s, bus.victim_way, exp);
    end
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_done set=%0d got=%b want=0", s, bus.busy);
    end
    got = int'(bus.victim_way);
    bus.touch = mode == 3;
    tick();
    bus.touch = 1'b0;
    if (mode == 3) model_touch(ts, tw);
`ifdef PLRU_AUTO_TOUCH_EN
    if (!(mode == 3 && ts == s)) model_touch(s, exp);
`endif
    vectors++;
    if (bus.victim_valid !== 1'b0 || bus.victim_way !== WAY_W'(exp)) begin
      miscompares++;
      $display("FAIL hold set=%0d got valid=%b way=%0d want valid=0 way=%0d", s, bus.victim_valid, bus.victim_way, exp);
    end
  endtask

  task automatic test_reset();
    int got;
    rst_n = 1'b0;
    tick();
    tick();
    vectors++;
    if ({bus.busy, bus.victim_valid, bus.victim_way} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs got busy=%b valid=%b way=%0d want 0 0 0", bus.busy, bus.victim_valid, bus.victim_way);
    end
    rst_n = 1'b1;
    model_clear();
    do_query(0, 0, 0, 0, got);
    vectors++;
    if (got !== 0) begin
      miscompares++;
      $display("FAIL reset_victim got=%0d want=0", got);
    end
  endtask

  task automatic test_basic();
    int got;
    do_touch(0, 0);
    do_query(0, 0, 0, 0, got);
    vectors++;
    if (got !== 4) begin
      miscompares++;
      $display("FAIL touch0_set0 got=%0d want=4", got);
    end
    do_query(1, 0, 0, 0, got);
    vectors++;
    if (got !== 0) begin
      miscompares++;
      $display("FAIL set1_untouched got=%0d want=0", got);
    end
  endtask

  task automatic test_sequence();
    int got;
    for (int w = 0; w < NUM_WAYS; w++) do_touch(2, w);
    do_query(2, 0, 0, 0, got);
    vectors++;
    if (got !== 0) begin
      miscompares++;
      $display("FAIL seq_all got=%0d want=0", got);
    end
    do_touch(2, 0);
    do_query(2, 0, 0, 0, got);
    vectors++;
    if (got !== 4) begin
      miscompares++;
      $display("FAIL seq_touch0 got=%0d want=4", got);
    end
  endtask

  task automatic test_snapshot();
    int got;
    do_query(3, 2, 3, 0, got);
    vectors++;
    if (got !== 0) begin
      miscompares++;
      $display("FAIL snapshot got=%0d want=0", got);
    end
    do_query(3, 0, 0, 0, got);
    vectors++;
    if (got !== 4) begin
      miscompares++;
      $display("FAIL after_snapshot got=%0d want=4", got);
    end
    do_query(6, 1, 6, 0, got);
  endtask

  task automatic test_back_to_back();
    int exp_q[$];
    int pend, e;
    pend = -1;
    bus.query_req = 1'b1;
    bus.query_set = SET_W'(4);
    for (int k = 0; k < 20; k++) begin
      if (k % 4 == 0) exp_q.push_back(model_victim(4));
`ifdef PLRU_AUTO_TOUCH_EN
      if (pend >= 0) model_touch(4, pend);
`endif
      pend = -1;
      tick();
      vectors++;
      if (bus.victim_valid !== (k % 4 == 3)) begin
        miscompares++;
        $display("FAIL b2b_valid edge=%0d got=%b want=%b", k, bus.victim_valid, k % 4 == 3);
      end
      if (k % 4 == 3 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        pend = e;
        vectors++;
        if (bus.victim_way !== WAY_W'(e)) begin
          miscompares++;
          $display("FAIL b2b_way edge=%0d got=%0d want=%0d", k, bus.victim_way, e);
        end
      end
    end
    bus.query_req = 1'b0;
    tick();
`ifdef PLRU_AUTO_TOUCH_EN
    if (pend >= 0) model_touch(4, pend);
`endif
  endtask

  task automatic test_reset_midwalk();
    bus.query_req = 1'b1;
    bus.query_set = SET_W'(6);
    tick();
    bus.query_req = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    model_clear();
    vectors++;
    if ({bus.busy, bus.victim_valid, bus.victim_way} !== '0) begin
      miscompares++;
      $display("FAIL midwalk_reset got busy=%b valid=%b way=%0d want 0 0 0", bus.busy, bus.victim_valid, bus.victim_way);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      vectors++;
      if (bus.victim_valid !== 1'b0 || bus.busy !== 1'b0) begin
        miscompares++;
        $display("FAIL midwalk_strobe cycle=%0d got valid=%b busy=%b want 0 0", k, bus.victim_valid, bus.busy);
      end
    end
  endtask

  task automatic test_auto_touch();
`ifdef PLRU_AUTO_TOUCH_EN
    int got;
    do_query(5, 0, 0, 0, got);
    vectors++;
    if (got !== 0) begin
      miscompares++;
      $display("FAIL auto_first got=%0d want=0", got);
    end
    do_query(5, 0, 0, 0, got);
    vectors++;
    if (got !== 4) begin
      miscompares++;
      $display("FAIL auto_second got=%0d want=4", got);
    end
`endif
  endtask

  task automatic test_random();
    int got, s, ts;
    for (int it = 0; it < 60; it++) begin
      for (int t = $urandom_range(0, 3); t > 0; t--)
        do_touch($urandom_range(0, NUM_SETS - 1), $urandom_range(0, NUM_WAYS - 1));
      s = $urandom_range(0, NUM_SETS - 1);
      ts = $urandom_range(0, 1) != 0 ? s : $urandom_range(0, NUM_SETS - 1);
      do_query(s, $urandom_range(0, 3), ts, $urandom_range(0, NUM_WAYS - 1), got);
    end
  endtask

  initial begin
    bus.touch = 1'b0;
    bus.touch_set = '0;
    bus.touch_way = '0;
    bus.query_req = 1'b0;
    bus.query_set = '0;
    test_reset();
    test_basic();
    test_sequence();
    test_snapshot();
    test_back_to_back();
    test_random();
    test_reset_midwalk();
    test_auto_touch();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/plru_tracker.md
# plru_tracker

Per-set tree pseudo-LRU state holder and victim selector for the set-associative cache. It sits alongside the cache datapath and records every hit/fill as a "touch" of (set, way). On a query handshake, it walks the set's tree one level per clock and returns the least-recently-used way. It is the update side of the replacement path: the controller feeds accesses in and reads victims back out.

## Interface
- NUM_WAYS, 8, associativity; power of two, ≥ 2
- NUM_SETS, 8, number of sets; power of two, ≥ 1
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- touch  in  1  record access of touch_way in touch_set this cycle
- touch_set  in  $clog2(NUM_SETS) (min 1)  set index of access
- touch_way  in  $clog2(NUM_WAYS)  way accessed
- query_req  in  1  request victim for query_set; accepted only when busy=0
- query_set  in  $clog2(NUM_SETS) (min 1)  set to search
- busy  out  1  walk in progress; query_req ignored
- victim_valid  out  1  one-cycle strobe; victim_way valid
- victim_way  out  $clog2(NUM_WAYS)  selected LRU way

## Operation
- State: per set, NUM_WAYS-1 tree bits in heap order; node 1 is the root, and node n has children 2n and 2n+1. Leaves map to ways 0..NUM_WAYS-1 from left to right.
- Bit semantics: 0 = LRU side is the left child; 1 = LRU side is the right child.
- Touch: for each node on the path from the root to touch_way, the bit is set to point away from the touched way. It is set to 1 if the path goes left, 0 if it goes right. Bits off the path are unchanged.
- FSM IDLE -> WALK -> DONE -> IDLE.
  - IDLE: busy=0. On query_req, snapshot the tree bits of query_set, set node=1, and go to WALK.
  - WALK: each cycle, node = 2*node + bit[node]. After L = log2(NUM_WAYS) steps, go to DONE.
  - DONE: victim_way = node - NUM_WAYS, victim_valid=1, busy=0. Go to IDLE, or accept a new query in the same cycle.
- The walk uses the snapshot, so touches during a walk never change the in-flight answer.
- Touch and query acceptance on the same set in the same edge: the snapshot takes the pre-touch bits, and the touch is still applied to the stored state.
- query_req while busy: dropped, with no side effect.
- Touch is accepted every cycle, independent of FSM state.

## Timing
- Reset (rst_n=0 at an edge): all tree bits 0, FSM IDLE, busy=0, victim_valid=0, victim_way=0.
- Reset mid-walk aborts the walk; no victim_valid is produced.
- Acceptance edge E0 → busy=1 from E0.
- victim_valid=1 and busy=0 in the cycle after edge E0+L, for exactly one cycle.
  - NUM_WAYS=8 → 3 cycles; NUM_WAYS=2 → 1 cycle.
- Back-to-back: query_req held high yields a victim every L+1 cycles.
- victim_way holds its last value while victim_valid=0.
- A touch takes effect at the edge where touch=1; a query accepted at the next edge sees it.

## Configuration
- PLRU_AUTO_TOUCH_EN, when defined: the cycle victim_valid=1, the tracker also touches (query set, victim_way), so the victim becomes MRU.
  - If an external touch targets the same set in that cycle, the external touch is applied and the auto-touch is dropped.
- PLRU_AUTO_TOUCH_EN, when undefined: no implicit update; the controller must touch the filled way explicitly.

## Structure
- Package plru_pkg holds:
  - the FSM state enum (IDLE, WALK, DONE)
  - the width localparams (way and set index widths, tree width NUM_WAYS-1)
  - a function computing the updated tree bits from (bits, way)
- Sub-module plru_touch_update: combinational tree-bit updater (bits in, way in, bits out).
  - Instantiated once for external touches, and once more when PLRU_AUTO_TOUCH_EN is defined.
- Tree storage is a flat register array indexed by set, reset by rst_n.

## Test plan
All scenarios use NUM_WAYS=8, NUM_SETS=8 unless noted.
- Reset, then query set 0 → busy for 3 cycles, then victim_valid with victim_way=0.
- Touch (0, way 0), then query set 0 → victim_way=4; set 1 still returns 0.
- Touch ways 0..7 in order on set 2, then query → victim_way=0. Touch way 0, query again → victim_way=4.
- Query set 3 accepted, then touch (3, 0) on the next cycle → victim_way=0 (snapshot). A second query on set 3 → victim_way=4.
- query_req held high for 20 cycles → victim_valid every 4 cycles; assert rst_n=0 mid-walk → no strobe, all outputs 0.
- With PLRU_AUTO_TOUCH_EN defined, two consecutive queries on set 5 after reset → victim_way=0, then 4.
